// File: rtl/decode_stage.sv
// Decode stage: splits fetched instructions into fields, classifies them and
// buffers up to two decoded packets so the busy signal toward fetch is registered.
module decode_stage #(
    parameter int EXEC_MASK_W = 64,
    parameter int ADDR_W      = 64,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [EXEC_MASK_W-1:0] fetch_exec_mask,
    input  logic [ADDR_W-1:0]      fetch_pc,
    input  logic [31:0]            fetch_insn,
    output logic                   decode_busy,
    output logic                   exec_valid,
    input  logic                   exec_busy,
    output logic [EXEC_MASK_W-1:0] exec_exec_mask,
    output logic [ADDR_W-1:0]      exec_pc,
    output logic [7:0]             exec_opcode,
    output logic [3:0]             exec_rd,
    output logic [3:0]             exec_rs1,
    output logic [3:0]             exec_rs2,
    output logic [63:0]            exec_imm,
    output logic                   exec_is_branch,
    output logic                   exec_is_mem,
    output logic                   exec_illegal,
    output logic                   halted,
    output logic                   protocol_error,
    output logic [31:0]            decoded_count,
    output logic [31:0]            stall_cycles
);

    // state | meaning
    // EMPTY | no decoded packet held
    // ONE   | one packet held, head valid toward execute
    // FULL  | two packets held, fetch is told to wait
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } q_state_t;

    typedef struct packed {
        logic [EXEC_MASK_W-1:0] mask;
        logic [ADDR_W-1:0]      pc;
        logic [7:0]             opcode;
        logic [3:0]             rd;
        logic [3:0]             rs1;
        logic [3:0]             rs2;
        logic [63:0]            imm;
        logic                   is_branch;
        logic                   is_mem;
        logic                   illegal;
    } entry_t;

    localparam logic [7:0] OP_HALT = 8'h00;

    if (DEPTH != 2) begin : g_depth_check
        $error("decode_stage only supports DEPTH == 2");
    end

    q_state_t    state_q, state_d;
    entry_t      slots [2];
    entry_t      new_entry;
    entry_t      head;
    logic        rd_ptr_q;
    logic        wr_sel;
    logic        busy_q;
    logic        halt_seen_q, halt_seen_d;
    logic        halted_q;
    logic        perr_q;
    logic [31:0] dcount_q;
    logic [31:0] stall_q;
    logic        enq, deq;

    always_comb begin
        new_entry           = '0;
        new_entry.mask      = fetch_exec_mask;
        new_entry.pc        = fetch_pc;
        new_entry.opcode    = fetch_insn[31:24];
        new_entry.rd        = fetch_insn[23:20];
        new_entry.rs1       = fetch_insn[19:16];
        new_entry.rs2       = fetch_insn[15:12];
        new_entry.imm       = {{52{fetch_insn[11]}}, fetch_insn[11:0]};
        new_entry.is_branch = (fetch_insn[31:24] == OP_HALT) ||
                              (fetch_insn[31:24] >= 8'h10 && fetch_insn[31:24] <= 8'h17);
        new_entry.is_mem    = (fetch_insn[31:24] == 8'h20) || (fetch_insn[31:24] == 8'h21) ||
                              (fetch_insn[31:24] == 8'h17);
        new_entry.illegal   = !((fetch_insn[31:24] <= 8'h17) || (fetch_insn[31:24] == 8'h20) ||
                                (fetch_insn[31:24] == 8'h21));
    end

    assign head       = slots[rd_ptr_q];
    assign exec_valid = (state_q != EMPTY);
    assign enq        = fetch_valid && !busy_q && !halt_seen_q;
    assign deq        = exec_valid && !exec_busy;
    // With one entry held, the free slot is the one after the head.
    assign wr_sel      = rd_ptr_q ^ (state_q == ONE);
    assign halt_seen_d = halt_seen_q || (enq && new_entry.opcode == OP_HALT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (enq) state_d = ONE;
            ONE: begin
                if (enq && !deq)      state_d = FULL;
                else if (!enq && deq) state_d = EMPTY;
            end
            FULL:    if (deq) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            slots[0]    <= '0;
            slots[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            busy_q      <= 1'b0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
            perr_q      <= 1'b0;
            dcount_q    <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            halt_seen_q <= halt_seen_d;
            busy_q      <= (state_d == FULL) || halt_seen_d;
            if (enq) slots[wr_sel] <= new_entry;
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
                dcount_q <= dcount_q + 32'd1;
                if (head.opcode == OP_HALT) halted_q <= 1'b1;
            end
            if (fetch_valid && busy_q) perr_q <= 1'b1;
            if (exec_valid && exec_busy && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
        end
    end

    assign decode_busy    = busy_q;
    assign exec_exec_mask = head.mask;
    assign exec_pc        = head.pc;
    assign exec_opcode    = head.opcode;
    assign exec_rd        = head.rd;
    assign exec_rs1       = head.rs1;
    assign exec_rs2       = head.rs2;
    assign exec_imm       = head.imm;
    assign exec_is_branch = head.is_branch;
    assign exec_is_mem    = head.is_mem;
    assign exec_illegal   = head.illegal;
    assign halted         = halted_q;
    assign protocol_error = perr_q;
    assign decoded_count  = dcount_q;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [63:0] fetch_exec_mask = '0;
    logic [63:0] fetch_pc = '0;
    logic [31:0] fetch_insn = '0;
    logic        decode_busy;
    logic        exec_valid;
    logic        exec_busy = 1'b0;
    logic [63:0] exec_exec_mask;
    logic [63:0] exec_pc;
    logic [7:0]  exec_opcode;
    logic [3:0]  exec_rd, exec_rs1, exec_rs2;
    logic [63:0] exec_imm;
    logic        exec_is_branch, exec_is_mem, exec_illegal;
    logic        halted, protocol_error;
    logic [31:0] decoded_count, stall_cycles;

    decode_stage #(.EXEC_MASK_W(64), .ADDR_W(64), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_exec_mask(fetch_exec_mask),
        .fetch_pc(fetch_pc), .fetch_insn(fetch_insn),
        .decode_busy(decode_busy), .exec_valid(exec_valid), .exec_busy(exec_busy),
        .exec_exec_mask(exec_exec_mask), .exec_pc(exec_pc), .exec_opcode(exec_opcode),
        .exec_rd(exec_rd), .exec_rs1(exec_rs1), .exec_rs2(exec_rs2), .exec_imm(exec_imm),
        .exec_is_branch(exec_is_branch), .exec_is_mem(exec_is_mem), .exec_illegal(exec_illegal),
        .halted(halted), .protocol_error(protocol_error),
        .decoded_count(decoded_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] mask;
        logic [63:0] pc;
        logic [31:0] insn;
    } pkt_t;

    pkt_t        exp_q[$];
    logic        m_busy = 0, m_halt_seen = 0, m_halted = 0, m_perr = 0;
    logic [31:0] m_dcount = 0, m_stall = 0;
    int          n_checks = 0, n_errors = 0;

    function automatic logic [63:0] ref_imm(logic [31:0] insn);
        return 64'($signed(insn[11:0]));
    endfunction

    // {is_branch, is_mem, illegal} from the opcode map
    function automatic logic [2:0] ref_class(logic [31:0] insn);
        int op;
        logic br, mem, ill;
        op  = int'(insn[31:24]);
        br  = (op == 0) || (op >= 16 && op <= 23);
        mem = (op == 32) || (op == 33) || (op == 23);
        ill = !((op <= 23) || (op == 32) || (op == 33));
        return {br, mem, ill};
    endfunction

    task automatic model_step();
        pkt_t p;
        logic v, deq, enq;
        if (reset) begin
            exp_q.delete();
            m_busy = 0; m_halt_seen = 0; m_halted = 0; m_perr = 0; m_dcount = 0; m_stall = 0;
            return;
        end
        v   = (exp_q.size() > 0);
        deq = v && !exec_busy;
        enq = fetch_valid && !m_busy && !m_halt_seen;
        if (fetch_valid && m_busy) m_perr = 1;
        if (v && exec_busy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (deq) begin
            if (exp_q[0].insn[31:24] == 8'h00) m_halted = 1;
            void'(exp_q.pop_front());
            m_dcount++;
        end
        if (enq) begin
            p.mask = fetch_exec_mask; p.pc = fetch_pc; p.insn = fetch_insn;
            exp_q.push_back(p);
            if (fetch_insn[31:24] == 8'h00) m_halt_seen = 1;
        end
        m_busy = (exp_q.size() == 2) || m_halt_seen;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] pc, input logic [31:0] insn);
        fetch_valid = 1; fetch_pc = pc; fetch_insn = insn;
        fetch_exec_mask = {$urandom(), $urandom()};
        tick();
        fetch_valid = 0;
    endtask

    task automatic reset_dut();
        reset = 1; fetch_valid = 0; exec_busy = 0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick(); tick();
        reset = 0;
        n_checks++; if (exec_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", exec_valid); end
        n_checks++; if (decode_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", decode_busy); end
        n_checks++; if ({halted, protocol_error} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got %b exp 00", {halted, protocol_error}); end
        n_checks++; if ({decoded_count, stall_cycles} !== 64'd0) begin n_errors++; $display("FAIL reset_counts got %h exp 0", {decoded_count, stall_cycles}); end
        n_checks++; if ({exec_pc, exec_opcode, exec_imm} !== '0) begin n_errors++; $display("FAIL reset_data got %h exp 0", {exec_pc, exec_opcode, exec_imm}); end
    endtask

    task automatic test_basic();
        logic [63:0] mask;
        exec_busy = 0;
        send(64'h0, 32'h0231_2ABC);
        mask = exp_q[0].mask;
        n_checks++; if (exec_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid got %b exp 1", exec_valid); end
        n_checks++; if (exec_opcode !== 8'h02) begin n_errors++; $display("FAIL basic_opcode got %h exp 02", exec_opcode); end
        n_checks++; if ({exec_rd, exec_rs1, exec_rs2} !== 12'h312) begin n_errors++; $display("FAIL basic_regs got %h exp 312", {exec_rd, exec_rs1, exec_rs2}); end
        n_checks++; if (exec_imm !== 64'hFFFF_FFFF_FFFF_FABC) begin n_errors++; $display("FAIL basic_imm got %h exp FFFFFFFFFFFFFABC", exec_imm); end
        n_checks++; if (exec_exec_mask !== mask) begin n_errors++; $display("FAIL basic_mask got %h exp %h", exec_exec_mask, mask); end
        n_checks++; if (exec_pc !== 64'h0) begin n_errors++; $display("FAIL basic_pc got %h exp 0", exec_pc); end
        tick();
        n_checks++; if (decoded_count !== 32'd1) begin n_errors++; $display("FAIL basic_count got %0d exp 1", decoded_count); end
        n_checks++; if (exec_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drained got %b exp 0", exec_valid); end
    endtask

    task automatic test_backpressure();
        reset_dut();
        exec_busy = 1;
        send(64'h0, 32'h0300_0001);
        send(64'h4, 32'h0400_0002);
        n_checks++; if (decode_busy !== 1'b1) begin n_errors++; $display("FAIL bp_busy got %b exp 1", decode_busy); end
        send(64'h8, 32'h0500_0003);
        n_checks++; if (protocol_error !== 1'b1) begin n_errors++; $display("FAIL bp_perr got %b exp 1", protocol_error); end
        n_checks++; if (exec_pc !== 64'h0) begin n_errors++; $display("FAIL bp_head got %h exp 0", exec_pc); end
        tick(); tick();
        n_checks++; if (stall_cycles !== 32'd4) begin n_errors++; $display("FAIL bp_stall got %0d exp 4", stall_cycles); end
        exec_busy = 0;
        tick();
        n_checks++; if (exec_pc !== 64'h4 || exec_valid !== 1'b1) begin n_errors++; $display("FAIL bp_second got pc %h v %b exp pc 4 v 1", exec_pc, exec_valid); end
        n_checks++; if (decoded_count !== 32'd1) begin n_errors++; $display("FAIL bp_count1 got %0d exp 1", decoded_count); end
        tick();
        n_checks++; if (exec_valid !== 1'b0 || decoded_count !== 32'd2) begin n_errors++; $display("FAIL bp_drain got v %b cnt %0d exp v 0 cnt 2", exec_valid, decoded_count); end
        n_checks++; if (stall_cycles !== m_stall) begin n_errors++; $display("FAIL bp_stall_hold got %0d exp %0d", stall_cycles, m_stall); end
    endtask

    task automatic test_classify();
        logic [7:0] ops [10] = '{8'h01, 8'h0F, 8'h10, 8'h17, 8'h18, 8'h1F, 8'h20, 8'h21, 8'h22, 8'hFF};
        logic [2:0] cls;
        reset_dut();
        send(64'h40, 32'h1100_0010);
        n_checks++; if (exec_is_branch !== 1'b1 || exec_illegal !== 1'b0) begin n_errors++; $display("FAIL cls_jmp_eq got br %b ill %b exp br 1 ill 0", exec_is_branch, exec_illegal); end
        send(64'h44, 32'h7F12_3456);
        n_checks++; if (exec_valid !== 1'b1 || exec_illegal !== 1'b1 || exec_pc !== 64'h44) begin n_errors++; $display("FAIL cls_illegal got v %b ill %b pc %h exp 1 1 44", exec_valid, exec_illegal, exec_pc); end
        for (int i = 0; i < 10; i++) begin
            send(64'h100 + 64'(i * 4), {ops[i], 24'($urandom())});
            cls = ref_class(exp_q[0].insn);
            n_checks++;
            if ({exec_is_branch, exec_is_mem, exec_illegal} !== cls || exec_opcode !== ops[i]) begin
                n_errors++;
                $display("FAIL cls_table op %h got %b exp %b", ops[i], {exec_is_branch, exec_is_mem, exec_illegal}, cls);
            end
        end
        tick();
        n_checks++; if (decoded_count !== 32'd12) begin n_errors++; $display("FAIL cls_count got %0d exp 12", decoded_count); end
    endtask

    task automatic test_halt();
        reset_dut();
        exec_busy = 1;
        send(64'h100, 32'h0100_0000);
        send(64'h104, 32'h0000_0000);
        n_checks++; if (decode_busy !== 1'b1 || halted !== 1'b0) begin n_errors++; $display("FAIL halt_busy got busy %b halted %b exp 1 0", decode_busy, halted); end
        exec_busy = 0;
        tick();
        n_checks++; if (exec_pc !== 64'h104 || halted !== 1'b0 || decode_busy !== 1'b1) begin n_errors++; $display("FAIL halt_nop_first got pc %h halted %b busy %b exp 104 0 1", exec_pc, halted, decode_busy); end
        tick();
        n_checks++; if (halted !== 1'b1 || exec_valid !== 1'b0 || decode_busy !== 1'b1) begin n_errors++; $display("FAIL halt_done got halted %b v %b busy %b exp 1 0 1", halted, exec_valid, decode_busy); end
        send(64'h108, 32'h0200_0000);
        n_checks++; if (protocol_error !== 1'b1 || exec_valid !== 1'b0) begin n_errors++; $display("FAIL halt_perr got perr %b v %b exp 1 0", protocol_error, exec_valid); end
    endtask

    task automatic test_reset_midop();
        reset_dut();
        exec_busy = 1;
        send(64'h200, 32'h0211_1111);
        send(64'h204, 32'h0322_2222);
        tick();
        n_checks++; if (decode_busy !== 1'b1) begin n_errors++; $display("FAIL rst_full got %b exp 1", decode_busy); end
        reset = 1;
        tick();
        reset = 0;
        n_checks++; if (exec_valid !== 1'b0 || decode_busy !== 1'b0 || halted !== 1'b0) begin n_errors++; $display("FAIL rst_flags got v %b busy %b halted %b exp 0 0 0", exec_valid, decode_busy, halted); end
        n_checks++; if (decoded_count !== 32'd0 || stall_cycles !== 32'd0) begin n_errors++; $display("FAIL rst_counts got %0d %0d exp 0 0", decoded_count, stall_cycles); end
        exec_busy = 0;
        send(64'h300, 32'h0433_3333);
        n_checks++; if (exec_valid !== 1'b1 || exec_pc !== 64'h300) begin n_errors++; $display("FAIL rst_accept got v %b pc %h exp 1 300", exec_valid, exec_pc); end
        tick();
    endtask

    task automatic test_back_to_back();
        int busy_seen = 0;
        reset_dut();
        exec_busy = 0;
        for (int i = 0; i < 100; i++) begin
            send(64'(i * 4), {8'($urandom_range(1, 255)), 24'($urandom())});
            n_checks++;
            if (exec_valid !== 1'b1 || exec_pc !== 64'(i * 4) || exec_opcode !== exp_q[0].insn[31:24]) begin
                n_errors++;
                $display("FAIL b2b_order pkt %0d got v %b pc %h exp pc %h", i, exec_valid, exec_pc, 64'(i * 4));
            end
            if (decode_busy !== 1'b0) busy_seen++;
            tick();
            if (decode_busy !== 1'b0) busy_seen++;
        end
        n_checks++; if (busy_seen != 0) begin n_errors++; $display("FAIL b2b_busy got %0d busy cycles exp 0", busy_seen); end
        n_checks++; if (decoded_count !== 32'd100) begin n_errors++; $display("FAIL b2b_count got %0d exp 100", decoded_count); end
    endtask

    task automatic test_random();
        pkt_t h;
        logic [7:0] op;
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 59) == 0) || m_halted;
            exec_busy = ($urandom_range(0, 2) == 0);
            fetch_valid = m_busy ? ($urandom_range(0, 19) == 0) : $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       op = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'h01;
                1:       op = 8'($urandom_range(8'h10, 8'h17));
                2:       op = 8'($urandom_range(8'h1F, 8'h22));
                default: op = 8'($urandom_range(1, 255));
            endcase
            fetch_insn      = {op, 24'($urandom())};
            fetch_pc        = {$urandom(), $urandom()};
            fetch_exec_mask = {$urandom(), $urandom()};
            tick();
            n_checks++;
            if (exec_valid !== (exp_q.size() > 0) || decode_busy !== m_busy) begin
                n_errors++;
                $display("FAIL rnd_ctrl cyc %0d got v %b busy %b exp v %b busy %b", c, exec_valid, decode_busy, exp_q.size() > 0, m_busy);
            end
            n_checks++;
            if ({halted, protocol_error} !== {m_halted, m_perr} || decoded_count !== m_dcount || stall_cycles !== m_stall) begin
                n_errors++;
                $display("FAIL rnd_status cyc %0d got %b %b %0d %0d exp %b %b %0d %0d", c, halted, protocol_error,
                         decoded_count, stall_cycles, m_halted, m_perr, m_dcount, m_stall);
            end
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                n_checks++;
                if (exec_pc !== h.pc || exec_exec_mask !== h.mask || exec_opcode !== h.insn[31:24] ||
                    {exec_rd, exec_rs1, exec_rs2} !== h.insn[23:12] || exec_imm !== ref_imm(h.insn) ||
                    {exec_is_branch, exec_is_mem, exec_illegal} !== ref_class(h.insn)) begin
                    n_errors++;
                    $display("FAIL rnd_head cyc %0d got pc %h op %h imm %h cls %b exp pc %h insn %h imm %h cls %b", c,
                             exec_pc, exec_opcode, exec_imm, {exec_is_branch, exec_is_mem, exec_illegal},
                             h.pc, h.insn, ref_imm(h.insn), ref_class(h.insn));
                end
            end
        end
        reset = 0; fetch_valid = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_classify();
        test_halt();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Stage directly downstream of instruction fetch.
- Accepts one fetched packet per handshake: execution mask, PC and one 32-bit instruction. Splits the instruction into opcode, register and immediate fields, classifies it, and presents a decoded packet to the register-read/execute stage.
- Holds up to two packets in an internal queue so the busy signal toward fetch can be registered. Stops accepting after a HALT has been decoded.

Parameters:
- EXEC_MASK_W, 64, width of the per-thread execution mask.
- ADDR_W, 64, width of memory_address_t (PC).
- DEPTH, 2, queue entries; only 2 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_valid  in  1  fetch presents a packet this cycle
- fetch_exec_mask  in  EXEC_MASK_W  mask of the fetched packet
- fetch_pc  in  ADDR_W  PC of the fetched instruction
- fetch_insn  in  32  instruction_t
- decode_busy  out  1  registered; fetch must not send while high
- exec_valid  out  1  decoded packet valid (head of queue)
- exec_busy  in  1  downstream cannot accept this cycle
- exec_exec_mask  out  EXEC_MASK_W  mask of the head entry
- exec_pc  out  ADDR_W  PC of the head entry
- exec_opcode  out  8  insn[31:24]
- exec_rd  out  4  insn[23:20]
- exec_rs1  out  4  insn[19:16]
- exec_rs2  out  4  insn[15:12]
- exec_imm  out  64  insn[11:0], sign-extended
- exec_is_branch  out  1  opcode changes control flow
- exec_is_mem  out  1  load or store
- exec_illegal  out  1  opcode not in the defined set
- halted  out  1  HALT has left the queue
- protocol_error  out  1  sticky; set when fetch_valid arrives while decode_busy is high
- decoded_count  out  32  packets handed downstream
- stall_cycles  out  32  cycles with exec_valid=1 and exec_busy=1

Behaviour:
- Reset (synchronous, active-high) applies on the next clk edge, also mid-operation. It clears the queue and all counters, deasserts every flag, and forces decode_busy=0, exec_valid=0, halted=0, protocol_error=0. Data outputs are 0.
- Opcode map:
  - 0x00 HALT.
  - 0x01 NOP.
  - 0x02–0x0F ALU ops.
  - 0x10–0x16 JMP_ALWAYS, EQ, NE, GT, GE, LT, LE.
  - 0x17 LOAD_RESTORE_PC.
  - 0x20 LOAD, 0x21 STORE.
  - Any other value: exec_illegal=1.
- exec_is_branch = 1 for HALT, 0x10–0x17. exec_is_mem = 1 for 0x20, 0x21, 0x17.
- Decode is combinational on entry write. Fields are stored in the queue, so outputs come straight from registers.
- Enqueue: fetch_valid && !decode_busy && !halt_seen. The packet is written at that edge, and exec_valid is high on the next cycle. Latency is 1 cycle when the queue is empty.
- Dequeue: exec_valid && !exec_busy. On the same edge the head advances and decoded_count increments.
- Simultaneous enqueue and dequeue: count stays unchanged and order is preserved (FIFO).
- decode_busy register = (count_next == 2) || halt_seen_next.
- fetch_valid while decode_busy=1: the packet is dropped and protocol_error is set, staying set until reset. The queue is unchanged.
- HALT:
  - halt_seen sets when a HALT is enqueued. After that no further enqueues occur and decode_busy stays high.
  - halted sets on the edge where the HALT entry is dequeued.
  - Entries already queued before the HALT still drain normally.
- Illegal opcodes are passed downstream flagged, not dropped.
- stall_cycles increments when exec_valid && exec_busy, and saturates at 0xFFFFFFFF. decoded_count wraps modulo 2^32.
- Queue states: EMPTY (count 0), ONE (1), FULL (2).
  - EMPTY → ONE on enqueue.
  - ONE → FULL on enqueue without dequeue.
  - ONE → EMPTY on dequeue without enqueue.
  - FULL → ONE on dequeue; no enqueue is possible because busy is high.

Test Plan:
- Reset, then fetch_valid with pc=0x0, insn=0x02312ABC, exec_busy=0 → next cycle exec_valid=1, opcode=0x02, rd=3, rs1=1, rs2=2, imm=0xFFFFFFFFFFFFFABC; then decoded_count=1.
- exec_busy=1; send two packets at pc 0x0 and 0x4 → decode_busy=1 after the second. A third fetch_valid sets protocol_error=1 and queue content is unchanged. Release exec_busy → pc 0x0 then 0x4 emerge; stall_cycles equals the held cycles.
- Send JMP_EQ 0x11000010 → exec_is_branch=1. Send opcode 0x7F → exec_illegal=1 and the packet is still delivered.
- Send NOP then HALT (0x00000000) → decode_busy stays 1 after HALT. NOP is delivered before HALT; halted=1 on the edge HALT dequeues. A further fetch_valid sets protocol_error.
- Assert reset while FULL with exec_busy=1 → the next cycle shows exec_valid=0, decode_busy=0, counters 0, halted=0; a new packet is accepted normally.
- Back-to-back traffic with exec_busy=0 and one packet every 2 cycles (fetch cadence) → decode_busy is never asserted and 100 packets are delivered in order with decoded_count=100.
